// File: rtl/conv_pkg.sv
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared state encodings, default dimensions and helpers for the
//            convolution sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int c_IFMAP_W = 4;
    localparam int c_IFMAP_H = 4;
    localparam int c_K       = 3;
    localparam int c_OUT_W   = c_IFMAP_W - c_K + 1;
    localparam int c_OUT_H   = c_IFMAP_H - c_K + 1;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE     = 3'd0;
    localparam state_t c_ST_LOAD_IF  = 3'd1;
    localparam state_t c_ST_LOAD_FLT = 3'd2;
    localparam state_t c_ST_COMPUTE  = 3'd3;
    localparam state_t c_ST_DRAIN    = 3'd4;
    localparam state_t c_ST_EMIT     = 3'd5;
    localparam state_t c_ST_FIN      = 3'd6;

    // Bit width able to hold 0..n-1, never narrower than one bit.
    function automatic int cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_win_cnt.sv
// ============================================================================
// Module   : conv_win_cnt
// Brief    : Nested kx/ky (tap) and ox/oy (pixel) window counters with
//            terminal flags and buffer read / output index generation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_win_cnt
    import conv_pkg::*;
#(
    parameter int IFMAP_W = c_IFMAP_W,
    parameter int IFMAP_H = c_IFMAP_H,
    parameter int K       = c_K,
    parameter int AW_I    = $clog2(IFMAP_W * IFMAP_H),
    parameter int AW_F    = $clog2(K * K),
    parameter int AW_O    = $clog2((IFMAP_W - K + 1) * (IFMAP_H - K + 1))
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            step_k,
    input  logic            step_o,
    output logic            k_first,
    output logic            k_last,
    output logic            o_last,
    output logic [AW_I-1:0] if_addr,
    output logic [AW_F-1:0] flt_addr,
    output logic [AW_O-1:0] out_idx
);

    localparam int c_OW  = IFMAP_W - K + 1;
    localparam int c_OH  = IFMAP_H - K + 1;
    localparam int c_KW  = cw(K);
    localparam int c_OXW = cw(c_OW);
    localparam int c_OYW = cw(c_OH);

    logic [c_KW-1:0]  r_kx;
    logic [c_KW-1:0]  r_ky;
    logic [c_OXW-1:0] r_ox;
    logic [c_OYW-1:0] r_oy;

    logic w_kx_end;
    logic w_ky_end;
    logic w_ox_end;
    logic w_oy_end;

    assign w_kx_end = (r_kx == c_KW'(K - 1));
    assign w_ky_end = (r_ky == c_KW'(K - 1));
    assign w_ox_end = (r_ox == c_OXW'(c_OW - 1));
    assign w_oy_end = (r_oy == c_OYW'(c_OH - 1));

    assign k_first = (r_kx == '0) && (r_ky == '0);
    assign k_last  = w_kx_end && w_ky_end;
    assign o_last  = w_ox_end && w_oy_end;

    assign if_addr  = AW_I'((int'(r_oy) + int'(r_ky)) * IFMAP_W + int'(r_ox) + int'(r_kx));
    assign flt_addr = AW_F'(int'(r_ky) * K + int'(r_kx));
    assign out_idx  = AW_O'(int'(r_oy) * c_OW + int'(r_ox));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_kx <= '0;
            r_ky <= '0;
            r_ox <= '0;
            r_oy <= '0;
        end else begin
            if (step_k) begin
                if (w_kx_end) begin
                    r_kx <= '0;
                    r_ky <= w_ky_end ? '0 : r_ky + c_KW'(1);
                end else begin
                    r_kx <= r_kx + c_KW'(1);
                end
            end
            if (step_o) begin
                if (w_ox_end) begin
                    r_ox <= '0;
                    r_oy <= w_oy_end ? '0 : r_oy + c_OYW'(1);
                end else begin
                    r_ox <= r_ox + c_OXW'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv_seq_ctrl.sv
// ============================================================================
// Module   : conv_seq_ctrl
// Brief    : Loads ifmap/filter words into their buffers, then sequences the
//            per-pixel MAC taps and flags finished output pixels.
//            Optional macro CONV_CTRL_OVF_EN adds the sticky ovf output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int IFMAP_W = c_IFMAP_W,
    parameter int IFMAP_H = c_IFMAP_H,
    parameter int K       = c_K,
    parameter int AW_I    = $clog2(IFMAP_W * IFMAP_H),
    parameter int AW_F    = $clog2(K * K),
    parameter int AW_O    = $clog2((IFMAP_W - K + 1) * (IFMAP_H - K + 1))
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            done_serial,
    output logic            ifmap_we,
    output logic [AW_I-1:0] ifmap_waddr,
    output logic            filt_we,
    output logic [AW_F-1:0] filt_waddr,
    output logic [AW_I-1:0] rd_ifmap_addr,
    output logic [AW_F-1:0] rd_filt_addr,
    output logic            mac_clr,
    output logic            mac_en,
    output logic            out_valid,
    output logic [AW_O-1:0] out_idx,
    output logic            busy,
    output logic            done
`ifdef CONV_CTRL_OVF_EN
    ,
    output logic            ovf
`endif
);

    localparam int c_N_IF = IFMAP_W * IFMAP_H;
    localparam int c_N_F  = K * K;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW_I-1:0] r_if_cnt;
    logic [AW_I-1:0] w_if_cnt_nxt;
    logic [AW_F-1:0] r_flt_cnt;
    logic [AW_F-1:0] w_flt_cnt_nxt;
    logic            r_tap_d;
    logic            r_first_d;

    logic            w_run;
    logic            w_acc;
    logic            w_tap;
    logic            w_win_clr;
    logic            w_step_o;
    logic            w_k_first;
    logic            w_k_last;
    logic            w_o_last;
    logic [AW_I-1:0] w_if_raddr;
    logic [AW_F-1:0] w_flt_raddr;

    // Reset overrides every strobe in the same cycle, not just the next one.
    assign w_run = en && !rst;
    assign w_acc = en && done_serial;

    conv_win_cnt #(
        .IFMAP_W (IFMAP_W),
        .IFMAP_H (IFMAP_H),
        .K       (K),
        .AW_I    (AW_I),
        .AW_F    (AW_F),
        .AW_O    (AW_O)
    ) u_win (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_win_clr),
        .step_k   (w_tap),
        .step_o   (w_step_o),
        .k_first  (w_k_first),
        .k_last   (w_k_last),
        .o_last   (w_o_last),
        .if_addr  (w_if_raddr),
        .flt_addr (w_flt_raddr),
        .out_idx  (out_idx)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_if_cnt_nxt  = r_if_cnt;
        w_flt_cnt_nxt = r_flt_cnt;
        w_win_clr     = 1'b0;
        w_step_o      = 1'b0;
        w_tap         = 1'b0;
        ifmap_we      = 1'b0;
        filt_we       = 1'b0;
        out_valid     = 1'b0;
        done          = 1'b0;
        if (w_run) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (done_serial) begin
                        ifmap_we     = 1'b1;
                        w_if_cnt_nxt = AW_I'(1);
                        w_state_nxt  = c_ST_LOAD_IF;
                    end
                end
                c_ST_LOAD_IF: begin
                    if (done_serial) begin
                        ifmap_we = 1'b1;
                        if (r_if_cnt == AW_I'(c_N_IF - 1)) begin
                            w_if_cnt_nxt = '0;
                            w_state_nxt  = c_ST_LOAD_FLT;
                        end else begin
                            w_if_cnt_nxt = r_if_cnt + AW_I'(1);
                        end
                    end
                end
                c_ST_LOAD_FLT: begin
                    if (done_serial) begin
                        filt_we = 1'b1;
                        if (r_flt_cnt == AW_F'(c_N_F - 1)) begin
                            w_flt_cnt_nxt = '0;
                            w_win_clr     = 1'b1;
                            w_state_nxt   = c_ST_COMPUTE;
                        end else begin
                            w_flt_cnt_nxt = r_flt_cnt + AW_F'(1);
                        end
                    end
                end
                c_ST_COMPUTE: begin
                    w_tap = 1'b1;
                    if (w_k_last) begin
                        w_state_nxt = c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    w_state_nxt = c_ST_EMIT;
                end
                c_ST_EMIT: begin
                    out_valid = 1'b1;
                    if (w_o_last) begin
                        w_win_clr   = 1'b1;
                        w_state_nxt = c_ST_FIN;
                    end else begin
                        w_step_o    = 1'b1;
                        w_state_nxt = c_ST_COMPUTE;
                    end
                end
                c_ST_FIN: begin
                    done        = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_if_cnt      <= '0;
            r_flt_cnt     <= '0;
            r_tap_d       <= 1'b0;
            r_first_d     <= 1'b0;
            rd_ifmap_addr <= '0;
            rd_filt_addr  <= '0;
        end else if (en) begin
            r_state   <= w_state_nxt;
            r_if_cnt  <= w_if_cnt_nxt;
            r_flt_cnt <= w_flt_cnt_nxt;
            r_tap_d   <= w_tap;
            r_first_d <= w_tap && w_k_first;
            if (w_tap) begin
                rd_ifmap_addr <= w_if_raddr;
                rd_filt_addr  <= w_flt_raddr;
            end
        end
    end

    assign ifmap_waddr = r_if_cnt;
    assign filt_waddr  = r_flt_cnt;
    assign mac_en      = w_run && r_tap_d;
    assign mac_clr     = w_run && r_tap_d && r_first_d;
    assign busy        = (r_state != c_ST_IDLE);

`ifdef CONV_CTRL_OVF_EN
    logic r_ovf;

    // A word arriving while the window is being walked has nowhere to go.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_acc && (r_state inside {c_ST_COMPUTE, c_ST_DRAIN, c_ST_EMIT, c_ST_FIN})) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire
